// File: rtl/esitleme_birimi_pkg.sv
// Shared constants and types for the histogram-equalisation block.
// Pixel width and logic levels are macros so port declarations can use them.
`ifndef SABITLER_VH
`define SABITLER_VH
`define PIXEL_BIT 8
`define HIGH 1'b1
`define LOW 1'b0
`endif

package esitleme_birimi_pkg;

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      YUKLE = 2'd1,
      BOL   = 2'd2,
      ESLE  = 2'd3
   } durum_t;

   localparam int BOLUNEN_BIT = 25;
   localparam logic [4:0] BOLME_ADIM = 5'd25;
   localparam logic [BOLUNEN_BIT-1:0] CARPAN = 25'd255;
   localparam logic [`PIXEL_BIT-1:0] PIKSEL_MAKS = 8'd255;

   // Clamp a quotient to the largest pixel value.
   function automatic logic [`PIXEL_BIT-1:0] doygun(input logic [BOLUNEN_BIT-1:0] bolum);
      logic [`PIXEL_BIT-1:0] sonuc;
      if (|bolum[BOLUNEN_BIT-1:`PIXEL_BIT]) begin
         sonuc = PIKSEL_MAKS;
      end else begin
         sonuc = bolum[`PIXEL_BIT-1:0];
      end
      return sonuc;
   endfunction

endpackage

// File: rtl/esitleme_birimi_bolucu.sv
// Restoring serial divider: one quotient bit per cycle, BOLME_ADIM cycles per division.
// bitti_o/bolum_o are valid together in the final step cycle.
module seri_bolucu
   import esitleme_birimi_pkg::*;
#(
   parameter int CDF_BIT = 17
)
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   baslat_i,
   input  logic [BOLUNEN_BIT-1:0] bolunen_i,
   input  logic [CDF_BIT-1:0]     bolen_i,
   output logic                   bitti_o,
   output logic [BOLUNEN_BIT-1:0] bolum_o
);

   logic [CDF_BIT-1:0]     kalan_r;
   logic [BOLUNEN_BIT-1:0] bolum_r;
   logic [CDF_BIT-1:0]     bolen_r;
   logic [4:0]             sayac_r;
   logic                   mesgul_r;

   logic [CDF_BIT:0]       deneme_s;
   logic [CDF_BIT-1:0]     kalan_s;
   logic                   bit_s;
   logic [BOLUNEN_BIT-1:0] bolum_s;
   logic                   bitti_s;

   // One restoring step; the true difference always fits in CDF_BIT bits.
   always_comb begin
      deneme_s = {kalan_r, bolum_r[BOLUNEN_BIT-1]};
      kalan_s  = deneme_s[CDF_BIT-1:0];
      bit_s    = `LOW;
      if (deneme_s >= {1'b0, bolen_r}) begin
         kalan_s = deneme_s[CDF_BIT-1:0] - bolen_r;
         bit_s   = `HIGH;
      end else begin
         kalan_s = deneme_s[CDF_BIT-1:0];
         bit_s   = `LOW;
      end
      bolum_s = {bolum_r[BOLUNEN_BIT-2:0], bit_s};
      bitti_s = mesgul_r && (sayac_r == (BOLME_ADIM - 5'd1));
   end

   // Division state: the quotient shifts in where the dividend shifts out.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         kalan_r  <= {CDF_BIT{1'b0}};
         bolum_r  <= {BOLUNEN_BIT{1'b0}};
         bolen_r  <= {CDF_BIT{1'b0}};
         sayac_r  <= 5'd0;
         mesgul_r <= `LOW;
      end else if (baslat_i) begin
         kalan_r  <= {CDF_BIT{1'b0}};
         bolum_r  <= bolunen_i;
         bolen_r  <= bolen_i;
         sayac_r  <= 5'd0;
         mesgul_r <= `HIGH;
      end else if (mesgul_r) begin
         kalan_r <= kalan_s;
         bolum_r <= bolum_s;
         if (bitti_s) begin
            mesgul_r <= `LOW;
            sayac_r  <= 5'd0;
         end else begin
            sayac_r <= sayac_r + 5'd1;
         end
      end
   end

   assign bitti_o = bitti_s;
   assign bolum_o = bolum_s;

endmodule

// File: rtl/esitleme_birimi.sv
// Histogram equalisation: builds a 256-entry LUT from a streamed CDF,
// then maps pixels through it with one cycle of latency.
module esitleme_birimi
   import esitleme_birimi_pkg::*;
#(
   parameter int CDF_BIT = 17
)
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  baslat_i,
   input  logic [CDF_BIT-1:0]    cdf_min_i,
   input  logic [CDF_BIT-1:0]    piksel_sayisi_i,
   input  logic                  cdf_gecerli_i,
   input  logic [CDF_BIT-1:0]    cdf_i,
   output logic                  cdf_hazir_o,
   input  logic                  pixel_gecerli_i,
   input  logic [`PIXEL_BIT-1:0] pixel_i,
   output logic                  pixel_gecerli_o,
   output logic [`PIXEL_BIT-1:0] pixel_o,
   output logic                  hazir_o
);

   durum_t                 durum_r, durum_s;
   logic [`PIXEL_BIT-1:0]  indeks_r, indeks_s;
   logic [CDF_BIT-1:0]     cdf_min_r;
   logic [CDF_BIT-1:0]     n_r;
   logic                   hazir_r, hazir_s;
   logic                   cdf_hazir_r;
   logic                   pg_r;
   logic [`PIXEL_BIT-1:0]  po_r;
   logic [`PIXEL_BIT-1:0]  lut_r [0:255];

   logic [CDF_BIT-1:0]     bolen_s;
   logic [CDF_BIT-1:0]     fark_s;
   logic [BOLUNEN_BIT-1:0] pay_s;
   logic                   bolucu_baslat_s;
   logic                   bolucu_bitti_s;
   logic [BOLUNEN_BIT-1:0] bolum_s;
   logic                   lut_yaz_s;
   logic [`PIXEL_BIT-1:0]  lut_veri_s;

   // Rounded numerator; bins below cdf_min contribute nothing.
   always_comb begin
      bolen_s = n_r - cdf_min_r;
      if (cdf_i > cdf_min_r) begin
         fark_s = cdf_i - cdf_min_r;
      end else begin
         fark_s = {CDF_BIT{1'b0}};
      end
      pay_s = BOLUNEN_BIT'(fark_s) * CARPAN + BOLUNEN_BIT'(bolen_s >> 1);
   end

   seri_bolucu #(
      .CDF_BIT (CDF_BIT)
   ) u_bolucu (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .baslat_i  (bolucu_baslat_s),
      .bolunen_i (pay_s),
      .bolen_i   (bolen_s),
      .bitti_o   (bolucu_bitti_s),
      .bolum_o   (bolum_s)
   );

   // Next-state logic; a start request overrides whatever is in progress.
   always_comb begin
      durum_s         = durum_r;
      indeks_s        = indeks_r;
      hazir_s         = hazir_r;
      lut_yaz_s       = `LOW;
      lut_veri_s      = indeks_r;
      bolucu_baslat_s = `LOW;
      if (baslat_i) begin
         durum_s  = YUKLE;
         indeks_s = 8'd0;
         hazir_s  = `LOW;
      end else begin
         case (durum_r)
            BOSTA: durum_s = BOSTA;
            YUKLE: begin
               if (cdf_gecerli_i) begin
                  if (bolen_s != {CDF_BIT{1'b0}}) begin
                     bolucu_baslat_s = `HIGH;
                     durum_s         = BOL;
                  end else begin
                     lut_yaz_s  = `HIGH;
                     lut_veri_s = indeks_r;
                  end
               end else begin
                  durum_s = YUKLE;
               end
            end
            BOL: begin
               if (bolucu_bitti_s) begin
                  lut_yaz_s  = `HIGH;
                  lut_veri_s = doygun(bolum_s);
               end else begin
                  durum_s = BOL;
               end
            end
            ESLE:    durum_s = ESLE;
            default: durum_s = BOSTA;
         endcase
         if (lut_yaz_s) begin
            if (indeks_r == PIKSEL_MAKS) begin
               durum_s = ESLE;
               hazir_s = `HIGH;
            end else begin
               indeks_s = indeks_r + 8'd1;
               durum_s  = YUKLE;
            end
         end else begin
            hazir_s = hazir_r;
         end
      end
   end

   // Control registers and the frame parameters captured at start.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_r     <= BOSTA;
         indeks_r    <= 8'd0;
         hazir_r     <= `LOW;
         cdf_hazir_r <= `LOW;
         cdf_min_r   <= {CDF_BIT{1'b0}};
         n_r         <= {CDF_BIT{1'b0}};
      end else begin
         durum_r     <= durum_s;
         indeks_r    <= indeks_s;
         hazir_r     <= hazir_s;
         cdf_hazir_r <= (durum_s == YUKLE);
         if (baslat_i) begin
            cdf_min_r <= cdf_min_i;
            n_r       <= piksel_sayisi_i;
         end
      end
   end

   // LUT storage is deliberately left unreset; hazir_o guards its contents.
   always_ff @(posedge clk_i) begin
      if (lut_yaz_s && !rst_i) begin
         lut_r[indeks_r] <= lut_veri_s;
      end
   end

   // Pixel mapping pipeline, active only while mapping.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pg_r <= `LOW;
         po_r <= 8'd0;
      end else if ((durum_r == ESLE) && !baslat_i) begin
         pg_r <= pixel_gecerli_i;
         po_r <= lut_r[pixel_i];
      end else begin
         pg_r <= `LOW;
      end
   end

   assign cdf_hazir_o     = cdf_hazir_r;
   assign hazir_o         = hazir_r;
   assign pixel_gecerli_o = pg_r;
   assign pixel_o         = po_r;

endmodule

// File: tb/tb_esitleme_birimi.sv
// Self-checking bench for esitleme_birimi: random CDF frames and pixels
// compared against an arithmetic reference of the equalisation rule.
module tb_esitleme_birimi;

   localparam int CB = 17;

   logic          clk = 1'b0;
   logic          rst;
   logic          baslat;
   logic [CB-1:0] cdf_min;
   logic [CB-1:0] piksel_sayisi;
   logic          cdf_gecerli;
   logic [CB-1:0] cdf;
   logic          cdf_hazir;
   logic          pixel_gecerli_in;
   logic [7:0]    pixel_in;
   logic          pixel_gecerli_out;
   logic [7:0]    pixel_out;
   logic          hazir;

   int hata   = 0;
   int toplam = 0;
   int cdf_tab [256];
   int lut_ref [256];

   always #5 clk = ~clk;

   esitleme_birimi #(.CDF_BIT(CB)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .baslat_i        (baslat),
      .cdf_min_i       (cdf_min),
      .piksel_sayisi_i (piksel_sayisi),
      .cdf_gecerli_i   (cdf_gecerli),
      .cdf_i           (cdf),
      .cdf_hazir_o     (cdf_hazir),
      .pixel_gecerli_i (pixel_gecerli_in),
      .pixel_i         (pixel_in),
      .pixel_gecerli_o (pixel_gecerli_out),
      .pixel_o         (pixel_out),
      .hazir_o         (hazir)
   );

   task automatic kontrol(input string etiket, input int gozlenen, input int beklenen);
      toplam++;
      if (gozlenen != beklenen) begin
         hata++;
         $display("FAIL %s: observed=%0d expected=%0d", etiket, gozlenen, beklenen);
      end
   endtask

   // Equalised value: round((cdf - cdf_min) * 255 / (N - cdf_min)), clamped.
   function automatic int ref_esle(input int idx, input int c, input int mn, input int n);
      longint d, pay, q;
      d = longint'(n) - longint'(mn);
      if (d == 0) return idx;
      pay = ((c > mn) ? longint'(c - mn) : 64'sd0) * 255 + d / 2;
      q = pay / d;
      return (q > 255) ? 255 : int'(q);
   endfunction

   task automatic tablo_rastgele(output int mn, output int n);
      int bos, cur;
      n   = $urandom_range(300, 100000);
      bos = $urandom_range(0, 40);
      cur = 0;
      for (int i = 0; i < 256; i++) begin
         if (i >= bos) cur += $urandom_range(0, 2 * n / 256);
         if (cur > n) cur = n;
         cdf_tab[i] = cur;
      end
      cdf_tab[255] = n;
      mn = n;
      for (int i = 255; i >= 0; i--) if (cdf_tab[i] != 0) mn = cdf_tab[i];
   endtask

   // Streams one frame's CDF; kes >= 0 stops after that many accepts.
   task automatic insa(input int mn, input int n, input int surekli, input int kes,
                       output int ilk, output int bitis, output int ara_hata, output int erken);
      int i, cyc, son, v, adim;
      ilk = -1; bitis = -1; ara_hata = 0; erken = 0; i = 0; cyc = 0; son = 0;
      adim = (n == mn) ? 1 : 26;
      if (kes < 0) for (int j = 0; j < 256; j++) lut_ref[j] = ref_esle(j, cdf_tab[j], mn, n);
      @(negedge clk);
      baslat = 1'b1; cdf_min = CB'(mn); piksel_sayisi = CB'(n); cdf_gecerli = 1'b0;
      @(negedge clk);
      baslat = 1'b0; cdf_min = CB'($urandom); piksel_sayisi = CB'($urandom);
      while (i < 256 && i != kes && cyc < 30000) begin
         v = surekli ? 1 : int'($urandom_range(0, 3) != 0);
         cdf_gecerli = v[0];
         cdf = CB'(cdf_tab[i]);
         if (hazir) erken++;
         if (v == 1 && cdf_hazir) begin
            if (ilk < 0) ilk = cyc;
            else if (surekli != 0 && (cyc - son) != adim) ara_hata++;
            son = cyc;
            i++;
         end
         @(negedge clk);
         cyc++;
      end
      cdf_gecerli = 1'b0;
      if (kes >= 0) return;
      while (!hazir && cyc < 40000) begin
         @(negedge clk);
         cyc++;
      end
      if (hazir) bitis = cyc;
   endtask

   // Pixel stream with optional reset pulse at cycle rst_at.
   task automatic esle(input int adet, input int rst_at, input int rastgele, input int tarama);
      int onceki_v, onceki_p, v, p;
      bit aktif;
      onceki_v = 0; onceki_p = 0; aktif = 1'b1;
      for (int k = 0; k <= adet; k++) begin
         @(negedge clk);
         kontrol("esle_gecerli", int'(pixel_gecerli_out), aktif ? onceki_v : 0);
         if (aktif && onceki_v == 1) kontrol("esle_piksel", int'(pixel_out), lut_ref[onceki_p]);
         rst = 1'b0;
         if (k < adet) begin
            v = rastgele ? int'($urandom_range(0, 3) != 0) : 1;
            p = tarama ? (k % 256) : int'($urandom_range(0, 255));
            pixel_gecerli_in = v[0];
            pixel_in = 8'(p);
            onceki_v = v; onceki_p = p;
            if (k == rst_at) begin
               rst = 1'b1;
               aktif = 1'b0;
            end
         end else begin
            pixel_gecerli_in = 1'b0;
         end
      end
   endtask

   task automatic tek_piksel(input string etiket, input int p, input int beklenen);
      @(negedge clk);
      pixel_in = 8'(p); pixel_gecerli_in = 1'b1;
      @(negedge clk);
      pixel_gecerli_in = 1'b0;
      kontrol({etiket, "_deger"}, int'(pixel_out), beklenen);
      kontrol({etiket, "_gecerli"}, int'(pixel_gecerli_out), 1);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int ilk, bitis, ara, erken, mn, n;
      rst = 1'b1; baslat = 1'b0; cdf_min = '0; piksel_sayisi = '0;
      cdf_gecerli = 1'b0; cdf = '0; pixel_gecerli_in = 1'b0; pixel_in = 8'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      kontrol("reset_pg", int'(pixel_gecerli_out), 0);
      kontrol("reset_po", int'(pixel_out), 0);
      kontrol("reset_hazir", int'(hazir), 0);
      kontrol("reset_cdf_hazir", int'(cdf_hazir), 0);
      rst = 1'b0;
      pixel_gecerli_in = 1'b1; pixel_in = 8'd5;
      @(negedge clk);
      kontrol("bosta_pg", int'(pixel_gecerli_out), 0);
      kontrol("bosta_cdf_hazir", int'(cdf_hazir), 0);
      pixel_gecerli_in = 1'b0;

      // Small frame N=16, cdf_min=2, continuous valid.
      for (int i = 0; i < 256; i++) begin
         if (i < 2) cdf_tab[i] = 0;
         else if (i < 9) cdf_tab[i] = 2;
         else if (i <= 10) cdf_tab[i] = 9;
         else cdf_tab[i] = 9 + ((i - 10) * 7) / 245;
      end
      cdf_tab[255] = 16;
      insa(2, 16, 1, -1, ilk, bitis, ara, erken);
      kontrol("a_sure", bitis - ilk, 6656);
      kontrol("a_aralik", ara, 0);
      kontrol("a_hazir_erken", erken, 0);
      esle(256, -1, 0, 1);
      tek_piksel("a_px10", 10, 128);
      tek_piksel("a_px255", 255, 255);

      // Uniform image, D = 0.
      for (int i = 0; i < 256; i++) cdf_tab[i] = 16;
      insa(16, 16, 1, -1, ilk, bitis, ara, erken);
      kontrol("b_sure", bitis - ilk, 256);
      kontrol("b_aralik", ara, 0);
      tek_piksel("b_px100", 100, 100);
      esle(64, -1, 1, 0);

      // Restart part-way through a build, then a complete rebuild.
      tablo_rastgele(mn, n);
      insa(mn, n, 0, 101, ilk, bitis, ara, erken);
      kontrol("c_kesme_hazir", int'(hazir), 0);
      tablo_rastgele(mn, n);
      insa(mn, n, 0, -1, ilk, bitis, ara, erken);
      kontrol("c_hazir_erken", erken, 0);
      kontrol("c_bitti", int'(bitis >= 0), 1);
      esle(256, -1, 1, 1);

      // Another random frame with random valid gaps.
      tablo_rastgele(mn, n);
      insa(mn, n, 0, -1, ilk, bitis, ara, erken);
      kontrol("d_bitti", int'(bitis >= 0), 1);
      esle(200, -1, 1, 0);

      // Back-to-back burst with a reset pulse in the middle.
      esle(300, 150, 0, 0);
      kontrol("e_hazir", int'(hazir), 0);
      kontrol("e_cdf_hazir", int'(cdf_hazir), 0);

      $display("Result: errors=%0d of %0d checks", hata, toplam);
      $finish;
   end

endmodule
